// File: rtl/bsr_pkg.sv
// Shared types and constants for the bidirectional PISO transmit controller.
package bsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/bsr_shift_reg.sv
// Parameterized bidirectional parallel-in/serial-out shift register.
module bsr_shift_reg
  import bsr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic [WIDTH-1:0] pin,
  output logic             sout
);

  logic [WIDTH-1:0] sr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= pin;
    end else if (shift_en) begin
      if (dir == DIR_LEFT) begin
        sr_reg <= {sr_reg[WIDTH-2:0], 1'b0};
      end else begin
        sr_reg <= {1'b0, sr_reg[WIDTH-1:1]};
      end
    end
  end

  // The bit leaving the register is the one presented on the serial line.
  assign sout = (dir == DIR_LEFT) ? sr_reg[WIDTH-1] : sr_reg[0];

endmodule

// File: rtl/bsr_piso_ctrl.sv
// Transmit controller: valid/ready word intake, serialization through
// bsr_shift_reg, and a programmable idle gap between words.
module bsr_piso_ctrl
  import bsr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t          state_reg, state_next;
  logic [CW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic            dir_reg;
  logic            load;
  logic            in_shift;
  logic            bit_last;
  logic            gap_last;
  logic            sr_sout;

  assign in_shift = (state_reg == SHIFT);
  assign bit_last = (bit_cnt_reg == CW'(WIDTH - 1));
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      dir_reg     <= DIR_RIGHT;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      if (load) begin
        dir_reg <= in_dir;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (bit_last) begin
          bit_cnt_next = '0;
          state_next   = (GAP > 0) ? bsr_pkg::GAP : IDLE;
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
      end
      bsr_pkg::GAP: begin
        if (gap_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  // The gap counter only exists when there is a gap to time.
  generate
    if (GAP > 0) begin : g_gap
      logic [GW-1:0] gap_cnt_reg;

      assign gap_last = (gap_cnt_reg == GW'(GAP - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          gap_cnt_reg <= '0;
        end else if (state_reg == bsr_pkg::GAP) begin
          gap_cnt_reg <= gap_last ? '0 : gap_cnt_reg + 1'b1;
        end
      end
    end else begin : g_no_gap
      assign gap_last = 1'b1;
    end
  endgenerate

  bsr_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (in_shift),
    .dir      (dir_reg),
    .pin      (in_data),
    .sout     (sr_sout)
  );

  // Every output is forced low while reset is asserted, even mid-frame.
  assign in_ready    = !rst && (state_reg == IDLE);
  assign sout_valid  = !rst && in_shift;
  assign sout        = sout_valid && sr_sout;
  assign frame_start = sout_valid && (bit_cnt_reg == '0);
  assign done        = sout_valid && bit_last;
  assign busy        = !rst && (state_reg != IDLE);

endmodule

// File: tb/tb_bsr_piso_ctrl.sv
// Directed bench for bsr_piso_ctrl: a WIDTH=4/GAP=1 instance and a WIDTH=8/GAP=0 instance.
module tb_bsr_piso_ctrl;

  logic       clk;
  int         n_assert;
  int         n_fail;

  logic       rst, in_valid, in_ready, in_dir;
  logic [3:0] in_data;
  logic       sout, sout_valid, frame_start, done, busy;

  logic       rst_b, in_valid_b, in_ready_b, in_dir_b;
  logic [7:0] in_data_b;
  logic       sout_b, sout_valid_b, frame_start_b, done_b, busy_b;

  bsr_piso_ctrl #(.WIDTH(4), .GAP(1)) dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_dir      (in_dir),
    .sout        (sout),
    .sout_valid  (sout_valid),
    .frame_start (frame_start),
    .done        (done),
    .busy        (busy)
  );

  bsr_piso_ctrl #(.WIDTH(8), .GAP(0)) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .in_data     (in_data_b),
    .in_dir      (in_dir_b),
    .sout        (sout_b),
    .sout_valid  (sout_valid_b),
    .frame_start (frame_start_b),
    .done        (done_b),
    .busy        (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet_a(input string tag, input logic exp_ready);
    chk({tag, "_sout"}, sout, 1'b0);
    chk({tag, "_sout_valid"}, sout_valid, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_in_ready"}, in_ready, exp_ready);
  endtask

  // Called at the falling edge of bit 0; checks four bits, leaves at the edge after bit 3.
  // seq[3] is the first bit expected on the wire. Optionally scrambles in_data/in_dir.
  task automatic frame_a(input string tag, input logic [3:0] seq, input bit scramble);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_b%0d_sout", tag, i), sout, seq[3-i]);
      chk($sformatf("%s_b%0d_valid", tag, i), sout_valid, 1'b1);
      chk($sformatf("%s_b%0d_fs", tag, i), frame_start, (i == 0));
      chk($sformatf("%s_b%0d_done", tag, i), done, (i == 3));
      chk($sformatf("%s_b%0d_ready", tag, i), in_ready, 1'b0);
      chk($sformatf("%s_b%0d_busy", tag, i), busy, 1'b1);
      $display("%s bit %0d: sout=%b valid=%b fs=%b done=%b", tag, i, sout, sout_valid, frame_start, done);
      if (scramble) begin
        in_data = ~in_data;
        in_dir  = ~in_dir;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] seq_b;
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 4'h0;
    in_dir     = 1'b0;
    rst_b      = 1'b1;
    in_valid_b = 1'b0;
    in_data_b  = 8'h00;
    in_dir_b   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_quiet_a("reset", 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", in_ready, 1'b1);
    $display("reset released: in_ready=%b", in_ready);

    // Basic left shift 1011
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    frame_a("left", 4'b1011, 1'b0);
    chk_quiet_a("left_gap", 1'b0);
    chk("left_gap_busy", busy, 1'b1);
    @(negedge clk);
    chk("left_idle_ready", in_ready, 1'b1);
    chk("left_idle_busy", busy, 1'b0);

    // Basic right shift 0111 -> 1,1,1,0
    in_valid = 1'b1; in_data = 4'b0111; in_dir = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    frame_a("right", 4'b1110, 1'b0);
    chk_quiet_a("right_gap", 1'b0);
    @(negedge clk);
    chk("right_idle_ready", in_ready, 1'b1);

    // Back-to-back: 1100 left, then 0011 right, in_valid held high
    in_valid = 1'b1; in_data = 4'b1100; in_dir = 1'b1;
    @(negedge clk);
    in_data = 4'b0011; in_dir = 1'b0;
    frame_a("b2b0", 4'b1100, 1'b0);
    chk_quiet_a("b2b_gap", 1'b0);
    @(negedge clk);
    chk_quiet_a("b2b_handshake", 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    frame_a("b2b1", 4'b1100, 1'b0);
    chk_quiet_a("b2b1_gap", 1'b0);
    @(negedge clk);
    chk_quiet_a("b2b_idle", 1'b1);
    @(negedge clk);
    chk_quiet_a("b2b_no_dup", 1'b1);
    chk("b2b_no_dup_busy", busy, 1'b0);

    // Inputs scrambled during SHIFT must not disturb 1011 left
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b1;
    @(negedge clk);
    frame_a("ignore", 4'b1011, 1'b1);
    in_valid = 1'b0;
    chk_quiet_a("ignore_gap", 1'b0);
    @(negedge clk);
    chk("ignore_idle_ready", in_ready, 1'b1);

    // Reset after bit 1 of 1011
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_b0_sout", sout, 1'b1);
    @(negedge clk);
    chk("abort_b1_sout", sout, 1'b0);
    chk("abort_b1_valid", sout_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk_quiet_a("abort_rst_comb", 1'b0);
    chk("abort_rst_comb_busy", busy, 1'b0);
    @(negedge clk);
    chk_quiet_a("abort_rst_edge", 1'b0);
    chk("abort_rst_edge_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    chk_quiet_a("abort_released", 1'b1);
    chk("abort_released_busy", busy, 1'b0);
    in_valid = 1'b1; in_data = 4'b0101; in_dir = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    frame_a("after_abort", 4'b0101, 1'b0);
    chk_quiet_a("after_abort_gap", 1'b0);
    @(negedge clk);

    // rst and in_valid together: no word accepted
    rst = 1'b1; in_valid = 1'b1; in_data = 4'b1111; in_dir = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk_quiet_a("rst_wins", 1'b1);
    chk("rst_wins_busy", busy, 1'b0);
    @(negedge clk);
    chk_quiet_a("rst_wins_next", 1'b1);
    chk("rst_wins_next_busy", busy, 1'b0);

    // WIDTH=8, GAP=0: 8'hA5 left -> 1,0,1,0,0,1,0,1
    rst_b = 1'b0;
    #1;
    chk("b_ready", in_ready_b, 1'b1);
    in_valid_b = 1'b1; in_data_b = 8'hA5; in_dir_b = 1'b1;
    seq_b = 8'b1010_0101;
    @(negedge clk);
    in_valid_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w8_b%0d_sout", i), sout_b, seq_b[7-i]);
      chk($sformatf("w8_b%0d_valid", i), sout_valid_b, 1'b1);
      chk($sformatf("w8_b%0d_fs", i), frame_start_b, (i == 0));
      chk($sformatf("w8_b%0d_done", i), done_b, (i == 7));
      chk($sformatf("w8_b%0d_ready", i), in_ready_b, 1'b0);
      $display("w8 bit %0d: sout=%b valid=%b fs=%b done=%b", i, sout_b, sout_valid_b, frame_start_b, done_b);
      @(negedge clk);
    end
    chk("w8_after_done_ready", in_ready_b, 1'b1);
    chk("w8_after_done_valid", sout_valid_b, 1'b0);
    chk("w8_after_done_busy", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
